conv_out_saver: RTL and testbench

//  Consumer end of the conv engine's pixel handshake (valid / out_pixel / save_done).

---
 rtl/conv_out_saver.sv | 171 +++++++++++++++++
 tb/tb_conv_out_saver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_saver.sv
// conv_out_saver: consumer end of the conv engine pixel handshake.
// Captures each pixel into the output feature-map buffer, either overwriting
// (first input channel) or saturating-accumulating (later channels), acks each
// pixel with a one-cycle save_done and flags the last pixel of a frame.
// The downstream layer reads the buffer through a registered read port.
module conv_out_saver #(
    parameter int K_H       = 3,
    parameter int K_W       = 3,
    parameter int MAX_H     = 16,
    parameter int MAX_W     = 15,
    parameter int ACC_WIDTH = 24,
    parameter int DEPTH     = 182
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 layer,
    input  logic                 first_ch,
    input  logic                 valid,
    input  logic [ACC_WIDTH-1:0] out_pixel,
    output logic                 save_done,
    output logic                 frame_done,
    output logic [7:0]           pix_cnt,
    input  logic [7:0]           rd_addr,
    output logic [ACC_WIDTH-1:0] rd_data
);

    // Output frame geometry of each layer
    localparam int L0_H   = MAX_H - K_H + 1;
    localparam int L0_W   = MAX_W - K_W + 1;
    localparam int L1_H   = L0_H - K_H + 1;
    localparam int L1_W   = L0_W - K_W + 1;
    localparam int FRAME0 = L0_H * L0_W;
    localparam int FRAME1 = L1_H * L1_W;

    localparam logic [7:0] LAST0   = 8'(FRAME0 - 1);
    localparam logic [7:0] LAST1   = 8'(FRAME1 - 1);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPT,
        S_ACK,
        S_DROP
    } state_t;

    state_t state_q, state_d;

    logic [ACC_WIDTH-1:0] mem [DEPTH];

    logic [ACC_WIDTH-1:0] pix_q;
    logic [ACC_WIDTH-1:0] old_q;
    logic [7:0]           wr_ptr_q;
    logic [7:0]           pix_cnt_q;
    logic                 last_q;
    logic                 abort;
    logic                 wr_en;
    logic [ACC_WIDTH-1:0] wr_data;
    logic [7:0]           frame_last;

    // Signed add clamped to the ACC_WIDTH range instead of wrapping
    function automatic logic [ACC_WIDTH-1:0] sat_add(
        input logic [ACC_WIDTH-1:0] a,
        input logic [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            if (s[ACC_WIDTH]) begin
                sat_add = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                sat_add = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_add = s[ACC_WIDTH-1:0];
        end
    endfunction

    assign abort      = rst | clear;
    assign frame_last = layer ? LAST1 : LAST0;
    assign wr_data    = first_ch ? pix_q : sat_add(old_q, pix_q);
    assign pix_cnt    = pix_cnt_q;

    // State register; rst and clear both abort the handshake back to IDLE
    always_ff @(posedge clk) begin
        if (abort) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus write strobe and ack outputs
    always_comb begin
        state_d    = state_q;
        wr_en      = 1'b0;
        save_done  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                wr_en   = ~abort;
                state_d = S_ACK;
            end
            S_ACK: begin
                save_done  = 1'b1;
                frame_done = last_q;
                state_d    = S_DROP;
            end
            S_DROP: begin
                // valid is still high for the pixel just acked; wait for it to fall
                if (!valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latch the incoming pixel and the entry it will be combined with
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && valid && !abort) begin
            pix_q <= out_pixel;
            old_q <= mem[wr_ptr_q];
        end
    end

    // Frame position: last-pixel flag decided in CAPT, pointers advance in ACK
    always_ff @(posedge clk) begin
        if (abort) begin
            pix_cnt_q <= '0;
            wr_ptr_q  <= '0;
            last_q    <= 1'b0;
        end else if (state_q == S_CAPT) begin
            last_q <= (pix_cnt_q == frame_last);
        end else if (state_q == S_ACK) begin
            if (last_q) begin
                pix_cnt_q <= '0;
                wr_ptr_q  <= '0;
            end else begin
                pix_cnt_q <= pix_cnt_q + 8'd1;
                wr_ptr_q  <= wr_ptr_q + 8'd1;
            end
        end
    end

    // Buffer write port (contents are never reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Registered read port; a same-cycle write to the same entry is not forwarded
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_addr < DEPTH_B) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_conv_out_saver.sv
// Self-checking bench for conv_out_saver: a table of saturation vectors,
// hand sequences for handshake corner cases, and random frames compared with
// an array-based model of the output buffer and frame counter.
module tb_conv_out_saver;

    localparam int DEPTH = 182;

    logic        clk = 1'b0;
    logic        rst, clear, layer, first_ch, valid;
    logic [23:0] out_pixel;
    logic        save_done, frame_done;
    logic [7:0]  pix_cnt, rd_addr;
    logic [23:0] rd_data;

    int total = 0;
    int bad   = 0;
    int fd_count = 0;
    int mdl [DEPTH];
    int model_cnt;
    int pix_arr [DEPTH];

    typedef struct {
        logic [23:0] stored;
        logic [23:0] pixel;
        logic [23:0] result;
    } sat_vec_t;
    sat_vec_t tbl [6];

    conv_out_saver #(
        .K_H(3), .K_W(3), .MAX_H(16), .MAX_W(15), .ACC_WIDTH(24), .DEPTH(182)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .layer(layer), .first_ch(first_ch),
        .valid(valid), .out_pixel(out_pixel), .save_done(save_done),
        .frame_done(frame_done), .pix_cnt(pix_cnt), .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic int sat24(input longint s);
        if (s > 64'sd8388607) return 8388607;
        if (s < -64'sd8388608) return -8388608;
        return int'(s);
    endfunction

    function automatic int to_s24(input logic [23:0] v);
        return int'($signed(v));
    endfunction

    function automatic int rnd24();
        logic [23:0] r;
        r = 24'($urandom);
        return to_s24(r);
    endfunction

    function automatic int frame_size();
        return layer ? 132 : 182;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic commit_model(input int pix, output int exp_fd);
        int e;
        e = model_cnt;
        mdl[e] = first_ch ? pix : sat24(longint'(mdl[e]) + longint'(pix));
        exp_fd = (model_cnt + 1 == frame_size()) ? 1 : 0;
        model_cnt = (model_cnt + 1) % frame_size();
    endtask

    // Offer one pixel, hold valid 'hold' cycles past the ack, then drop it
    task automatic send_pixel(input int pix, input int hold);
        int waited;
        bit got;
        int efd;
        waited = 0;
        got = 1'b0;
        out_pixel = 24'(pix);
        valid = 1'b1;
        while (!got && waited < 12) begin
            @(negedge clk);
            waited++;
            got = (save_done === 1'b1);
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
            valid = 1'b0;
            repeat (4) @(negedge clk);
            return;
        end
        chk("ack_latency", waited, 2);
        commit_model(pix, efd);
        chk("frame_done", frame_done, efd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_no_ack", save_done, 0);
            chk("hold_pix_cnt", pix_cnt, model_cnt);
        end
        valid = 1'b0;
        @(negedge clk);
        chk("pix_cnt", pix_cnt, model_cnt);
        chk("no_ack_after", save_done, 0);
        chk("frame_done_low", frame_done, 0);
        @(negedge clk);
    endtask

    task automatic run_frame(input int n, input int maxhold);
        for (int i = 0; i < n; i++) begin
            send_pixel(pix_arr[i], int'($urandom_range(0, maxhold)));
        end
    endtask

    task automatic read_check(input string name, input int addr, input int exp);
        rd_addr = 8'(addr);
        @(negedge clk);
        chk(name, to_s24(rd_data), exp);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        int fd0;
        int oldv;
        int newv;
        int efd;

        tbl[0] = '{24'h7FFFF0, 24'h000100, 24'h7FFFFF};
        tbl[1] = '{24'h800010, 24'hFFFF00, 24'h800000};
        tbl[2] = '{24'h000005, 24'hFFFFFD, 24'h000002};
        tbl[3] = '{24'h7FFFFF, 24'h000000, 24'h7FFFFF};
        tbl[4] = '{24'h800000, 24'hFFFFFF, 24'h800000};
        tbl[5] = '{24'h400000, 24'h3FFFFF, 24'h7FFFFF};

        rst = 1'b1; clear = 1'b0; valid = 1'b0; layer = 1'b0; first_ch = 1'b1;
        out_pixel = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_save_done", save_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        model_cnt = 0;

        // T1: overwrite frame, layer 0, pixel i at entry i
        layer = 1'b0; first_ch = 1'b1;
        for (int i = 0; i < DEPTH; i++) pix_arr[i] = i;
        fd0 = fd_count;
        run_frame(DEPTH, 0);
        chk("t1_frame_done_count", fd_count - fd0, 1);
        chk("t1_pix_cnt_wrap", pix_cnt, 0);
        for (int i = 0; i < DEPTH; i++) read_check("t1_buf", i, i);

        // T2: overwrite with 100 at entry 0, then accumulate -30 / i
        pix_arr[0] = 100;
        run_frame(DEPTH, 0);
        first_ch = 1'b0;
        pix_arr[0] = -30;
        run_frame(DEPTH, 1);
        read_check("t2_entry0", 0, 70);
        for (int i = 1; i < DEPTH; i += 9) read_check("t2_double", i, 2 * i);

        // T3 (layer 1): table of stored/pixel pairs through saturation
        layer = 1'b1; first_ch = 1'b1;
        for (int i = 0; i < DEPTH; i++) pix_arr[i] = rnd24();
        for (int i = 0; i < 6; i++) pix_arr[i] = to_s24(tbl[i].stored);
        fd0 = fd_count;
        run_frame(132, 0);
        first_ch = 1'b0;
        for (int i = 0; i < DEPTH; i++) pix_arr[i] = rnd24();
        for (int i = 0; i < 6; i++) pix_arr[i] = to_s24(tbl[i].pixel);
        run_frame(132, 0);
        chk("t3_frame_done_count", fd_count - fd0, 2);
        for (int i = 0; i < 6; i++) read_check("t3_sat", i, to_s24(tbl[i].result));
        for (int i = 6; i < 132; i++) read_check("t3_model", i, mdl[i]);

        // T4: valid held six cycles past the ack, then next pixel accepted
        first_ch = 1'b1;
        send_pixel(1234, 6);
        send_pixel(-77, 0);
        read_check("t4_entry0", 0, 1234);
        read_check("t4_entry1", 1, -77);

        // T5: clear while pixel 50 is in CAPT
        pulse_clear();
        for (int i = 0; i < 50; i++) pix_arr[i] = rnd24();
        run_frame(50, 1);
        oldv = mdl[50];
        out_pixel = 24'h123456;
        valid = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        chk("t5_no_ack", save_done, 0);
        chk("t5_pix_cnt", pix_cnt, 0);
        clear = 1'b0;
        model_cnt = 0;
        // valid still high as clear falls: captured as the first pixel of a new frame
        send_pixel(-5000, 0);
        read_check("t5_entry50_kept", 50, oldv);
        read_check("t5_entry0_new", 0, -5000);

        // T6: read of entry 5 colliding with its write
        for (int i = 1; i < 5; i++) send_pixel(i * 11, 0);
        oldv = mdl[5];
        newv = rnd24();
        rd_addr = 8'd5;
        out_pixel = 24'(newv);
        valid = 1'b1;
        @(negedge clk);
        chk("t6_before", to_s24(rd_data), oldv);
        @(negedge clk);
        chk("t6_ack", save_done, 1);
        chk("t6_collide_old", to_s24(rd_data), oldv);
        commit_model(newv, efd);
        chk("t6_frame_done", frame_done, efd);
        valid = 1'b0;
        @(negedge clk);
        chk("t6_after_new", to_s24(rd_data), newv);
        chk("t6_pix_cnt", pix_cnt, model_cnt);
        @(negedge clk);
        read_check("t6_oob_182", 182, 0);
        read_check("t6_oob_200", 200, 0);
        read_check("t6_oob_255", 255, 0);

        // Random accumulate frame on layer 0 with random hold times
        pulse_clear();
        layer = 1'b0; first_ch = 1'b0;
        for (int i = 0; i < DEPTH; i++) pix_arr[i] = rnd24();
        fd0 = fd_count;
        run_frame(DEPTH, 2);
        chk("rand_frame_done_count", fd_count - fd0, 1);
        for (int i = 0; i < DEPTH; i++) read_check("rand_buf", i, mdl[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
